// File: rtl/mandel_pixel_scheduler_if.sv
// Core dispatch/result bus and framebuffer write port of the Mandelbrot pixel scheduler.
// master = scheduler side, slave = iteration cores plus framebuffer side.
interface mandel_pixel_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int ITER_W    = 8,
    parameter int ADDR_W    = 19
);
    logic [NUM_CORES-1:0]        core_start;
    logic [X_W-1:0]              core_x;
    logic [Y_W-1:0]              core_y;
    logic [NUM_CORES-1:0]        core_idle;
    logic [NUM_CORES-1:0]        core_done;
    logic [NUM_CORES*ITER_W-1:0] core_iter;
    logic [NUM_CORES-1:0]        core_ack;
    logic                        fb_we;
    logic [ADDR_W-1:0]           fb_addr;
    logic [ITER_W-1:0]           fb_data;
    logic                        fb_ready;

    modport master (
        output core_start, core_x, core_y, core_ack, fb_we, fb_addr, fb_data,
        input  core_idle, core_done, core_iter, fb_ready
    );

    modport slave (
        input  core_start, core_x, core_y, core_ack, fb_we, fb_addr, fb_data,
        output core_idle, core_done, core_iter, fb_ready
    );
endinterface

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order pixel dispatcher for NUM_CORES Mandelbrot cores, with round-robin
// result arbitration onto a single buffered framebuffer write port.
module mandel_pixel_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int ITER_W    = 8,
    parameter int ADDR_W    = 19
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    frame_done_o,
    mandel_pixel_scheduler_if.master bus
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic [PTR_W-1:0]       dispPtr_q, dispPtr_d;
    logic [PTR_W-1:0]       wbPtr_q, wbPtr_d;
    logic [NUM_CORES-1:0]   outstanding_q, outstanding_d;
    logic [X_W-1:0]         tagX_q [NUM_CORES];
    logic [Y_W-1:0]         tagY_q [NUM_CORES];
    logic [NUM_CORES-1:0]   coreStart_q, coreStart_d;
    logic [X_W-1:0]         coreX_q, coreX_d;
    logic [Y_W-1:0]         coreY_q, coreY_d;
    logic                   fbWe_q, fbWe_d;
    logic [ADDR_W-1:0]      fbAddr_q, fbAddr_d;
    logic [ITER_W-1:0]      fbData_q, fbData_d;
    logic [NUM_CORES-1:0]   ack;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   candidates;
    logic                   dispValid;
    logic                   capValid;
    logic [PTR_W-1:0]       dispIdx;
    logic [PTR_W-1:0]       capIdx;
    logic                   lastPixel;

    // First requester at or after ptr, wrapping modulo NUM_CORES.
    function automatic logic [PTR_W-1:0] rrPick(input logic [NUM_CORES-1:0] req,
                                                 input logic [PTR_W-1:0]     ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(ptr) + k) % NUM_CORES;
            if (!found && req[idx]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] i);
        return PTR_W'((int'(i) + 1) % NUM_CORES);
    endfunction

    assign eligible   = bus.core_idle & ~outstanding_q;
    assign candidates = bus.core_done & outstanding_q;
    assign dispValid  = (state_q == RUN) && (eligible != '0);
    // The single buffer slot may be refilled in the same cycle its contents are accepted.
    assign capValid   = ((state_q == RUN) || (state_q == DRAIN)) &&
                        (!fbWe_q || bus.fb_ready) && (candidates != '0);
    assign dispIdx    = rrPick(eligible, dispPtr_q);
    assign capIdx     = rrPick(candidates, wbPtr_q);
    assign lastPixel  = (x_q == X_W'(H_RES - 1)) && (y_q == Y_W'(V_RES - 1));

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        dispPtr_d     = dispPtr_q;
        wbPtr_d       = wbPtr_q;
        outstanding_d = outstanding_q;
        coreStart_d   = '0;
        coreX_d       = coreX_q;
        coreY_d       = coreY_q;
        fbWe_d        = fbWe_q;
        fbAddr_d      = fbAddr_q;
        fbData_d      = fbData_q;
        ack           = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: begin
                if (dispValid) begin
                    coreStart_d[dispIdx]   = 1'b1;
                    coreX_d                = x_q;
                    coreY_d                = y_q;
                    outstanding_d[dispIdx] = 1'b1;
                    dispPtr_d              = nextPtr(dispIdx);
                    if (lastPixel) begin
                        state_d = DRAIN;
                    end else if (x_q == X_W'(H_RES - 1)) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && !fbWe_q && !capValid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fbWe_q && bus.fb_ready) begin
            fbWe_d = 1'b0;
        end
        if (capValid) begin
            ack[capIdx]           = 1'b1;
            fbWe_d                = 1'b1;
            fbAddr_d              = ADDR_W'(tagY_q[capIdx]) * ADDR_W'(H_RES) +
                                    ADDR_W'(tagX_q[capIdx]);
            fbData_d              = bus.core_iter[int'(capIdx)*ITER_W +: ITER_W];
            outstanding_d[capIdx] = 1'b0;
            wbPtr_d               = nextPtr(capIdx);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            dispPtr_q     <= '0;
            wbPtr_q       <= '0;
            outstanding_q <= '0;
            coreStart_q   <= '0;
            coreX_q       <= '0;
            coreY_q       <= '0;
            fbWe_q        <= 1'b0;
            fbAddr_q      <= '0;
            fbData_q      <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dispPtr_q     <= dispPtr_d;
            wbPtr_q       <= wbPtr_d;
            outstanding_q <= outstanding_d;
            coreStart_q   <= coreStart_d;
            coreX_q       <= coreX_d;
            coreY_q       <= coreY_d;
            fbWe_q        <= fbWe_d;
            fbAddr_q      <= fbAddr_d;
            fbData_q      <= fbData_d;
        end
    end

    // Each core remembers which pixel it is working on so its result can be addressed.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                tagX_q[i] <= '0;
                tagY_q[i] <= '0;
            end
        end else if (dispValid) begin
            tagX_q[dispIdx] <= x_q;
            tagY_q[dispIdx] <= y_q;
        end
    end

    assign busy_o         = (state_q == RUN) || (state_q == DRAIN);
    assign frame_done_o   = (state_q == DONE);
    assign bus.core_start = coreStart_q;
    assign bus.core_x     = coreX_q;
    assign bus.core_y     = coreY_q;
    assign bus.core_ack   = ack;
    assign bus.fb_we      = fbWe_q;
    assign bus.fb_addr    = fbAddr_q;
    assign bus.fb_data    = fbData_q;

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler: behavioural cores with random latency,
// a raster-order reference of dispatched pixels and a per-address expected-write table.
module tb_mandel_pixel_scheduler;

    localparam int NC = 4;
    localparam int HR = 6;
    localparam int VR = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int IW = 8;
    localparam int AW = 19;

    typedef struct {
        int x;
        int y;
    } coord_t;

    logic clk;
    logic resetn;
    logic start;
    logic busy;
    logic frameDone;

    mandel_pixel_scheduler_if #(.NUM_CORES(NC), .X_W(XW), .Y_W(YW), .ITER_W(IW), .ADDR_W(AW)) bus ();

    mandel_pixel_scheduler #(
        .NUM_CORES(NC), .H_RES(HR), .V_RES(VR),
        .X_W(XW), .Y_W(YW), .ITER_W(IW), .ADDR_W(AW)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
        .busy_o       (busy),
        .frame_done_o (frameDone),
        .bus          (bus)
    );

    int      checks = 0;
    int      errors = 0;
    int      seed = 0;
    int      readyMode = 0;
    int      maxLat = 3;
    int      coreLat [NC];
    int      cnt [NC];
    int      cx [NC];
    int      cy [NC];
    coord_t  expDisp [$];
    int      pending [int];
    int      writeLog [$];
    int      ackLog [$];
    int      writes = 0;
    bit      doneSeen = 0;
    int      cyc = 0;
    int      lastWriteCycle = 0;
    bit [NC-1:0] tbOut = '0;
    logic    prevWe = 0;
    logic    prevReady = 0;
    logic    prevDone = 0;
    logic [AW-1:0] prevAddr = '0;
    logic [IW-1:0] prevData = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int iterFn(input int x, input int y);
        return (x * 37 + y * 11 + seed) & 255;
    endfunction

    function automatic int oneHotIdx(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name, input int act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=%0d required=none (t=%0t)", name, act, $time);
    endtask

    // Behavioural iteration cores: accept a pixel, wait a latency, hold the result until acked.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.core_idle <= '1;
            bus.core_done <= '0;
            bus.core_iter <= '0;
            for (int i = 0; i < NC; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (bus.core_done[i] && bus.core_ack[i]) begin
                    bus.core_done[i] <= 1'b0;
                    bus.core_idle[i] <= 1'b1;
                end else if (bus.core_start[i]) begin
                    bus.core_idle[i] <= 1'b0;
                    cx[i]  <= int'(bus.core_x);
                    cy[i]  <= int'(bus.core_y);
                    cnt[i] <= (coreLat[i] > 0) ? coreLat[i] : int'($urandom_range(1, maxLat));
                end else if (!bus.core_idle[i] && !bus.core_done[i]) begin
                    if (cnt[i] <= 1) begin
                        bus.core_done[i] <= 1'b1;
                        bus.core_iter[i*IW +: IW] <= IW'(iterFn(cx[i], cy[i]));
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                end
            end
        end
    end

    // Framebuffer acceptance: always ready, random, or stalled.
    initial begin
        bus.fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: bus.fb_ready = 1'b1;
                1: bus.fb_ready = ($urandom_range(0, 9) < 7);
                default: bus.fb_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the raster reference on each dispatch and retires expected writes.
    initial begin : monitor
        int i;
        int a;
        coord_t c;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                tbOut     = '0;
                prevWe    = 1'b0;
                prevReady = 1'b0;
                prevDone  = 1'b0;
            end else begin
                if (bus.core_start != '0) begin
                    checkOutput("dispOneHot", 32'($onehot(bus.core_start)), 1);
                    i = oneHotIdx(bus.core_start);
                    checkOutput("dispToFreeCore", 32'(tbOut[i]), 0);
                    if (expDisp.size() == 0) begin
                        failNow("dispBeyondFrame", int'(bus.core_x));
                    end else begin
                        c = expDisp.pop_front();
                        checkOutput("dispX", 32'(bus.core_x), c.x);
                        checkOutput("dispY", 32'(bus.core_y), c.y);
                        pending[c.y * HR + c.x] = iterFn(c.x, c.y);
                    end
                    tbOut[i] = 1'b1;
                end
                if (bus.core_ack != '0) begin
                    checkOutput("ackOneHot", 32'($onehot(bus.core_ack)), 1);
                    i = oneHotIdx(bus.core_ack);
                    checkOutput("ackHasResult", 32'(bus.core_done[i] & tbOut[i]), 1);
                    checkOutput("ackWhileBufBlocked", 32'(bus.fb_we & ~bus.fb_ready), 0);
                    tbOut[i] = 1'b0;
                    ackLog.push_back(i);
                end
                if (prevWe && !prevReady) begin
                    checkOutput("stallWeHeld", 32'(bus.fb_we), 1);
                    checkOutput("stallAddrHeld", 32'(bus.fb_addr), 32'(prevAddr));
                    checkOutput("stallDataHeld", 32'(bus.fb_data), 32'(prevData));
                end
                if (bus.fb_we && bus.fb_ready) begin
                    a = int'(bus.fb_addr);
                    if (pending.exists(a)) begin
                        checkOutput("wrData", 32'(bus.fb_data), pending[a]);
                        pending.delete(a);
                    end else begin
                        failNow("wrUnexpectedAddr", a);
                    end
                    writes++;
                    lastWriteCycle = cyc;
                    writeLog.push_back(a);
                end
                if (frameDone) begin
                    checkOutput("doneIsPulse", 32'(prevDone), 0);
                    checkOutput("doneAfterAllWrites", writes, HR * VR);
                    checkOutput("doneSoonAfterLastWrite",
                                32'((cyc - lastWriteCycle >= 1) && (cyc - lastWriteCycle <= 2)), 1);
                    doneSeen = 1'b1;
                end
                prevWe    = bus.fb_we;
                prevReady = bus.fb_ready;
                prevAddr  = bus.fb_addr;
                prevData  = bus.fb_data;
                prevDone  = frameDone;
            end
        end
    end

    task automatic doReset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstFrameDone", 32'(frameDone), 0);
        checkOutput("rstCoreStart", 32'(bus.core_start), 0);
        checkOutput("rstCoreXY", 32'({bus.core_x, bus.core_y}), 0);
        checkOutput("rstCoreAck", 32'(bus.core_ack), 0);
        checkOutput("rstFbWe", 32'(bus.fb_we), 0);
        checkOutput("rstFbAddrData", 32'({bus.fb_addr, bus.fb_data}), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        checkOutput("postRstBusy", 32'(busy), 0);
        checkOutput("postRstIdleOutputs", 32'({bus.core_start, bus.fb_we}), 0);
    endtask

    // One frame: build the raster reference, start, optionally stall/restart/abort, then drain.
    task automatic applyStimulus(input bit firstAfterReset, input int stallCycles,
                                 input bit midStart, input int abortAfter);
        int savedMode;
        seed = int'($urandom_range(0, 255));
        expDisp.delete();
        pending.delete();
        writeLog.delete();
        ackLog.delete();
        writes   = 0;
        doneSeen = 1'b0;
        for (int y = 0; y < VR; y++) begin
            for (int x = 0; x < HR; x++) begin
                expDisp.push_back('{x: x, y: y});
            end
        end
        savedMode = readyMode;
        if (stallCycles > 0) readyMode = 2;

        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("busyAfterStart", 32'(busy), 1);
        if (firstAfterReset) begin
            @(negedge clk);
            checkOutput("firstCoreStart", 32'(bus.core_start), 1);
            checkOutput("firstCoreXY", 32'({bus.core_x, bus.core_y}), 0);
        end
        if (stallCycles > 0) begin
            repeat (stallCycles) @(negedge clk);
            checkOutput("allCoresOutstandingInStall", 32'($countones(tbOut)), NC);
            checkOutput("fbWeHeldInStall", 32'(bus.fb_we), 1);
            readyMode = savedMode;
        end
        if (midStart) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            checkOutput("busyAfterIgnoredStart", 32'(busy), 1);
        end
        if (abortAfter > 0) begin
            repeat (abortAfter) @(posedge clk);
            #3 resetn = 1'b0;
            #1;
            checkOutput("abortBusy", 32'(busy), 0);
            checkOutput("abortCoreStart", 32'(bus.core_start), 0);
            checkOutput("abortCoreAck", 32'(bus.core_ack), 0);
            checkOutput("abortFb", 32'({bus.fb_we, bus.fb_addr, bus.fb_data}), 0);
            repeat (2) @(posedge clk);
            #1 resetn = 1'b1;
            return;
        end

        for (int c = 0; c < 3000 && !doneSeen; c++) @(negedge clk);
        if (!doneSeen) failNow("frameDoneTimeout", writes);
        @(negedge clk);
        @(negedge clk);
        checkOutput("busyAfterFrame", 32'(busy), 0);
        checkOutput("allPixelsWritten", 32'(pending.num()), 0);
        checkOutput("allPixelsDispatched", 32'(expDisp.size()), 0);
        checkOutput("writeCount", writes, HR * VR);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < NC; i++) coreLat[i] = 0;

        $display("[TB] reset and fixed-latency frame");
        doReset();
        readyMode = 0;
        for (int i = 0; i < NC; i++) coreLat[i] = 3;
        applyStimulus(1'b1, 0, 1'b0, 0);

        $display("[TB] simultaneous results from cores 1 and 3");
        doReset();
        coreLat[0] = 20;
        coreLat[1] = 4;
        coreLat[2] = 20;
        coreLat[3] = 2;
        applyStimulus(1'b1, 0, 1'b0, 0);
        if (ackLog.size() >= 2 && writeLog.size() >= 2) begin
            checkOutput("tieAck0", ackLog[0], 1);
            checkOutput("tieAck1", ackLog[1], 3);
            checkOutput("tieAddr0", writeLog[0], 1);
            checkOutput("tieAddr1", writeLog[1], 3);
        end else begin
            failNow("tieLogTooShort", writeLog.size());
        end

        $display("[TB] framebuffer stall");
        for (int i = 0; i < NC; i++) coreLat[i] = 0;
        maxLat    = 3;
        readyMode = 1;
        applyStimulus(1'b0, 12, 1'b0, 0);

        $display("[TB] start ignored during RUN");
        applyStimulus(1'b0, 0, 1'b1, 0);

        $display("[TB] reset mid-frame then restart");
        applyStimulus(1'b0, 0, 1'b0, 8);
        applyStimulus(1'b1, 0, 1'b0, 0);

        $display("[TB] random frames");
        repeat (3) begin
            maxLat    = int'($urandom_range(1, 8));
            readyMode = 1;
            applyStimulus(1'b0, 0, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
